memctrl_rr: RTL

- N-channel, byte-serial memory controller. Successor to the two-client LSB/icache controller.
- Arbitrates round-robin among NUM_CH requesters (icache, LSB, future prefetch/DMA) for the single 8-bit unified RAM port.
- Sequences 1/2/4-byte loads and stores byte by byte, little-endian.
- Returns assembled, sign- or zero-extended load data with a per-channel done pulse.

---
 rtl/memctrl_pkg.sv | 38 +++
 rtl/memctrl_rr_arbiter.sv | 30 +++
 rtl/memctrl_rr.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/memctrl_pkg.sv
// Shared constants and helpers for the round-robin byte-serial memory controller.
package memctrl_pkg;

    localparam logic [2:0] W_B  = 3'd0;
    localparam logic [2:0] W_H  = 3'd1;
    localparam logic [2:0] W_W  = 3'd2;
    localparam logic [2:0] W_BU = 3'd4;
    localparam logic [2:0] W_HU = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Codes 3/6/7 are not real widths and fall through to a full word.
    function automatic logic [2:0] width_to_nbytes(input logic [2:0] w);
        logic [2:0] n;
        case (w)
            W_B, W_BU: n = 3'd1;
            W_H, W_HU: n = 3'd2;
            W_W:       n = 3'd4;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [2:0]  nbytes,
                                                input logic        sgn);
        logic [31:0] v;
        case (nbytes)
            3'd1:    v = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
            3'd2:    v = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/memctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int CH_W = 3
) (
    input  logic [N-1:0]    req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [CH_W-1:0] gnt_idx_o,
    output logic            any_o
);
    logic [CH_W-1:0] cur_s;
    logic            hit_s;

    // Walk the ring once starting after the last winner.
    always_comb begin
        cur_s     = ptr_i;
        hit_s     = 1'b0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_s     = (cur_s == CH_W'(N - 1)) ? '0 : cur_s + CH_W'(1);
            hit_s     = req_i[cur_s] && !any_o;
            gnt_idx_o = hit_s ? cur_s : gnt_idx_o;
            any_o     = any_o || hit_s;
        end
        gnt_o = any_o ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/memctrl_rr.sv
// N-channel byte-serial memory controller: round-robin arbitration onto one 8-bit RAM port,
// little-endian 1/2/4-byte sequencing, sign/zero-extended load return.
module memctrl_rr
    import memctrl_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int CH_W   = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [3*NUM_CH-1:0]      width,
    input  logic [ADDR_W*NUM_CH-1:0] addr,
    input  logic [32*NUM_CH-1:0]     wdata,
    output logic [NUM_CH-1:0]        grant,
    output logic [NUM_CH-1:0]        done,
    output logic [31:0]              rdata,
    output logic                     busy
);
    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, ptr_q, ptr_d, gnt_idx_s;
    logic              we_q, we_d, sgn_q, sgn_d, busy_q, busy_d, mem_wr_q, mem_wr_d, any_s;
    logic [2:0]        nbytes_q, nbytes_d, idx_q, idx_d, cap_k_s, sel_w_s;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
    logic [31:0]       wdata_q, wdata_d, data_q, data_d, rdata_q, rdata_d, cap_s;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic [NUM_CH-1:0] grant_q, grant_d, done_q, done_d, gnt_s;
    logic [2:0]        width_a [NUM_CH];
    logic [ADDR_W-1:0] addr_a  [NUM_CH];
    logic [31:0]       wdata_a [NUM_CH];

    rr_arbiter #(.N(NUM_CH), .CH_W(CH_W)) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .any_o     (any_s)
    );

    // Split the flattened per-channel buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            width_a[i] = width[i*3 +: 3];
            addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = wdata[i*32 +: 32];
        end
    end

    // Next-state logic; cap_s is the load word with this cycle's RAM byte merged in.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        ptr_d      = ptr_q;
        we_d       = we_q;
        sgn_d      = sgn_q;
        busy_d     = busy_q;
        nbytes_d   = nbytes_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        grant_d    = grant_q;
        done_d     = done_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;
        mem_dout_d = mem_dout_q;
        sel_w_s    = width_a[gnt_idx_s];
        cap_k_s    = idx_q - 3'd2;
        cap_s      = data_q;
        cap_s[{cap_k_s[1:0], 3'b000} +: 8] = mem_din;

        case (state_q)
            ST_IDLE: begin
                mem_wr_d = 1'b0;
                mem_a_d  = '0;
                if (any_s) begin
                    ch_d       = gnt_idx_s;
                    we_d       = we[gnt_idx_s];
                    nbytes_d   = width_to_nbytes(sel_w_s);
                    sgn_d      = !sel_w_s[2];
                    addr_d     = addr_a[gnt_idx_s];
                    wdata_d    = wdata_a[gnt_idx_s];
                    data_d     = 32'd0;
                    grant_d    = gnt_s;
                    ptr_d      = gnt_idx_s;
                    busy_d     = 1'b1;
                    mem_a_d    = addr_a[gnt_idx_s];
                    mem_wr_d   = we[gnt_idx_s];
                    mem_dout_d = wdata_a[gnt_idx_s][7:0];
                    idx_d      = 3'd1;
                    state_d    = ST_XFER;
                end else begin
                    grant_d = '0;
                end
            end
            ST_XFER: begin
                grant_d = '0;
                if (idx_q < nbytes_q) begin
                    mem_a_d    = addr_q + ADDR_W'(idx_q);
                    mem_wr_d   = we_q;
                    mem_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                end else begin
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                end
                // RAM returns the byte for address k-2 at edge k.
                if (!we_q && idx_q >= 3'd2) begin
                    data_d = cap_s;
                end else begin
                    data_d = data_q;
                end
                if (idx_q == nbytes_q + 3'd1) begin
                    done_d  = NUM_CH'(1) << ch_q;
                    rdata_d = we_q ? rdata_q : extend_load(cap_s, nbytes_q, sgn_q);
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                done_d  = '0;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                done_d   = '0;
                grant_d  = '0;
                busy_d   = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State registers: reset wins, rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            ptr_q      <= CH_W'(NUM_CH - 1);
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            busy_q     <= 1'b0;
            nbytes_q   <= 3'd0;
            idx_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            rdata_q    <= 32'd0;
            grant_q    <= '0;
            done_q     <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= 8'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            sgn_q      <= sgn_d;
            busy_q     <= busy_d;
            nbytes_q   <= nbytes_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;
    assign grant    = grant_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;

endmodule
